register_status_file: RTL
=========================

Name: register_status_file

Overview:
- Architectural register file plus per-register rename tag table.
- Serves as the responder end of the reorder-buffer launch/commit/dependency-query interface.
- On launch, a register is tagged with the producing ROB id. On commit, the value is written and the tag is retired if it still matches. On query, the block returns the current tag and value for two source registers.
- Flush (clear) drops all pending tags while keeping committed values.

Parameters:
- XLEN, 32, data width of each register.
- ROB_ID_W, 5, ROB id width; id 0 means "no dependency". Valid ROB ids are 1..31.
- NUM_REGS, 32, architectural register count; x0 is hardwired zero.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; all state holds when low
- _clear  input  1  misprediction flush from the ROB
- _rf_launch_ready  input  1  a new instruction with rd is dispatched this cycle
- _rf_launch_rob_id  input  ROB_ID_W  ROB slot of the dispatched instruction
- _rf_launch_register_id  input  5  destination register
- _rf_commit_ready  input  1  head instruction with rd is retiring this cycle
- _rf_commit_rob_id  input  ROB_ID_W  ROB slot being retired
- _rf_commit_register_id  input  5  destination register of the retiring instruction
- _rf_commit_value  input  XLEN  result being retired
- _ask_rd_1  input  5  source register 1 query
- _ask_rd_2  input  5  source register 2 query
- _dep_rd_1  output  ROB_ID_W  pending producer tag of _ask_rd_1 (0 = none)
- _dep_rd_2  output  ROB_ID_W  pending producer tag of _ask_rd_2
- _dep_value_1  output  XLEN  architectural value of _ask_rd_1
- _dep_value_2  output  XLEN  architectural value of _ask_rd_2

Behaviour:
- State: value[0..31] (XLEN bits) and tag[0..31] (ROB_ID_W bits). Both are updated on posedge clk_in only when rdy_in=1.
- Reset: when rst_in=0, all value and tag entries clear to 0 immediately (asynchronous). All outputs then read 0.
- x0: writes and launches to register 0 are ignored. value[0] and tag[0] read 0 always.
- Commit, when _rf_commit_ready=1 and reg r != 0:
  - value[r] <= _rf_commit_value.
  - tag[r] <= 0 only if tag[r] == _rf_commit_rob_id; a younger in-flight producer keeps its tag.
- Launch, when _rf_launch_ready=1, _clear=0 and reg r != 0: tag[r] <= _rf_launch_rob_id.
- Launch and commit to the same r in the same cycle:
  - value is written.
  - tag ends equal to the launch id (launch wins).
- Clear, when _clear=1:
  - every tag <= 0.
  - any launch that cycle is dropped.
  - a simultaneous commit still writes its value.
- Queries are combinational with single-cycle latency 0:
  - _dep_rd_k = tag[_ask_rd_k]
  - _dep_value_k = value[_ask_rd_k]
- Commit bypass: if _rf_commit_ready=1, _ask_rd_k == _rf_commit_register_id != 0, and tag[_ask_rd_k] == _rf_commit_rob_id, then the outputs are _dep_rd_k = 0 and _dep_value_k = _rf_commit_value.
- No launch bypass: queries in the launch cycle belong to the launching instruction and must see the pre-launch tag.
- Queries are not affected by rdy_in. When rdy_in=0, outputs still reflect the held state.
- ROB id wrap (31 -> 1) needs no special handling; tags are compared by equality only.
- Implementation scope: single always block for the sequential state plus combinational read muxes, roughly 120-180 lines.

Test Plan:
1. Reset and x0:
   - Stimulus: rst_in=0 with registers previously written, release; then commit x0=0xDEADBEEF.
   - Required: every register reads dep 0 / value 0 after release, and a query of x0 still returns 0/0.
2. Launch then commit:
   - Stimulus: launch rob 3 to x5; next cycle query x5; then commit rob 3, x5, 0x1234.
   - Required: query returns dep 3; after commit, query returns dep 0, value 0x1234.
   - Required: during the commit cycle itself the bypass already returns dep 0, value 0x1234.
3. Stale commit:
   - Stimulus: launch rob 4 to x7, launch rob 6 to x7, commit rob 4 to x7 with value 0x55.
   - Required: x7 reads dep 6, value 0x55.
4. Same-cycle launch and commit:
   - Stimulus: x9 tagged 2; in one cycle commit rob 2 to x9 (0xAA) and launch rob 8 to x9.
   - Required: x9 reads dep 8, value 0xAA.
   - Required: a query of x9 during that cycle returns dep 0, value 0xAA.
5. Clear:
   - Stimulus: tag x1..x4 with ids 1..4, then assert _clear together with launch rob 5 to x10 and commit rob 1 to x1 (0x77).
   - Required: all tags are 0, x10 is untagged, and x1 value is 0x77.
6. rdy_in hold:
   - Stimulus: rdy_in=0 while launch rob 9 to x12 is presented.
   - Required: x12 tag is unchanged.
   - Required: with rdy_in=1 the next cycle, the tag becomes 9.

Source files
------------

// File: rtl/register_status_file.sv
// rtl/register_status_file.sv - architectural register file with per-register rename tag table
//
// Responder end of the ROB launch/commit/dependency-query interface.
// Launch tags a destination register with its producing ROB id. Commit writes
// the value and retires the tag only if it still names the committing slot.
// Two combinational query ports return the pending tag and the architectural
// value, with a bypass for the instruction committing this cycle. Clear drops
// every pending tag but keeps committed values. x0 is hardwired to zero.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global hold when low)
//   _clear                                  ROB misprediction flush
//   _rf_launch_ready/_rob_id/_register_id   dispatch of an instruction with rd
//   _rf_commit_ready/_rob_id/_register_id/_value  retirement of the head instruction
//   _ask_rd_1/_ask_rd_2                     source register queries
//   _dep_rd_1/_dep_rd_2                     pending producer tag (0 = none)
//   _dep_value_1/_dep_value_2               architectural value
module register_status_file #(
   parameter int XLEN     = 32,
   parameter int ROB_ID_W = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                _clear,
   input  logic                _rf_launch_ready,
   input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
   input  logic [4:0]          _rf_launch_register_id,
   input  logic                _rf_commit_ready,
   input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
   input  logic [4:0]          _rf_commit_register_id,
   input  logic [XLEN-1:0]     _rf_commit_value,
   input  logic [4:0]          _ask_rd_1,
   input  logic [4:0]          _ask_rd_2,
   output logic [ROB_ID_W-1:0] _dep_rd_1,
   output logic [ROB_ID_W-1:0] _dep_rd_2,
   output logic [XLEN-1:0]     _dep_value_1,
   output logic [XLEN-1:0]     _dep_value_2
);

   logic [XLEN-1:0]     value_q [NUM_REGS];
   logic [ROB_ID_W-1:0] tag_q   [NUM_REGS];

   // One-hot register selects; bit 0 is forced low so x0 never changes.
   logic [NUM_REGS-1:0] commit_sel;
   logic [NUM_REGS-1:0] launch_sel;

   always_comb begin
      commit_sel = '0;
      launch_sel = '0;
      if (_rf_commit_ready)
         commit_sel[_rf_commit_register_id] = 1'b1;
      // A flush cancels any launch presented in the same cycle.
      if (_rf_launch_ready && !_clear)
         launch_sel[_rf_launch_register_id] = 1'b1;
      commit_sel[0] = 1'b0;
      launch_sel[0] = 1'b0;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else if (rdy_in) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (commit_sel[i])
               value_q[i] <= _rf_commit_value;
            // Priority: flush, then a new launch, then retirement of a
            // matching tag. A stale commit leaves a younger producer's tag.
            if (_clear)
               tag_q[i] <= '0;
            else if (launch_sel[i])
               tag_q[i] <= _rf_launch_rob_id;
            else if (commit_sel[i] && (tag_q[i] == _rf_commit_rob_id))
               tag_q[i] <= '0;
         end
      end
   end

   // Commit bypass: the retiring result is visible in its own cycle, but only
   // when the register is still owned by the committing slot. Launches are
   // deliberately not bypassed.
   logic bypass_1;
   logic bypass_2;

   assign bypass_1 = _rf_commit_ready && (_ask_rd_1 != 5'd0) &&
                     (_ask_rd_1 == _rf_commit_register_id) &&
                     (tag_q[_ask_rd_1] == _rf_commit_rob_id);
   assign bypass_2 = _rf_commit_ready && (_ask_rd_2 != 5'd0) &&
                     (_ask_rd_2 == _rf_commit_register_id) &&
                     (tag_q[_ask_rd_2] == _rf_commit_rob_id);

   assign _dep_rd_1    = bypass_1 ? '0 : tag_q[_ask_rd_1];
   assign _dep_rd_2    = bypass_2 ? '0 : tag_q[_ask_rd_2];
   assign _dep_value_1 = bypass_1 ? _rf_commit_value : value_q[_ask_rd_1];
   assign _dep_value_2 = bypass_2 ? _rf_commit_value : value_q[_ask_rd_2];

endmodule
